// File: rtl/mmix_mem_arbiter.sv
// Two-requester arbiter merging instruction fetch and load/store onto the mem_* command bus.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed dp-over-if priority.
module mmix_mem_arbiter #(
  parameter int          ADDR_W  = 64,
  parameter logic [1:0]  IF_SIZE = 2'd2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] if_address,
  input  logic              if_read,
  output logic [63:0]       if_readdata,
  output logic              if_done,
  input  logic [ADDR_W-1:0] dp_address,
  input  logic [1:0]        dp_datasize,
  input  logic              dp_read,
  input  logic              dp_write,
  input  logic [63:0]       dp_writedata,
  output logic [63:0]       dp_readdata,
  output logic              dp_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [1:0]        mem_datasize,
  output logic              mem_read,
  output logic              mem_write,
  output logic [63:0]       mem_writedata,
  input  logic [63:0]       mem_readdata,
  input  logic              mem_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IF  = 2'd1,
    GNT_DP  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t state;
  logic   dp_req;
  logic   grant_dp;

`ifdef MEM_ARB_RR_EN
  // 1 = fetch port won the last grant; the reset value lets fetch win the first contention.
  logic last_grant;

  always_comb begin
    dp_req   = dp_read | dp_write;
    grant_dp = dp_req & (~if_read | last_grant);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      last_grant <= 1'b0;
    else if (state == IDLE && (dp_req || if_read))
      last_grant <= ~grant_dp;
  end
`else
  always_comb begin
    dp_req   = dp_read | dp_write;
    grant_dp = dp_req;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      mem_address   <= '0;
      mem_datasize  <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_writedata <= '0;
      if_readdata   <= '0;
      dp_readdata   <= '0;
      if_done       <= 1'b0;
      dp_done       <= 1'b0;
    end else begin
      if_done <= 1'b0;
      dp_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dp) begin
            mem_address   <= dp_address;
            mem_datasize  <= dp_datasize;
            mem_writedata <= dp_writedata;
            mem_write     <= dp_write;
            mem_read      <= ~dp_write;
            state         <= GNT_DP;
          end else if (if_read) begin
            mem_address   <= if_address & ~ADDR_W'(3);
            mem_datasize  <= IF_SIZE;
            mem_writedata <= '0;
            mem_write     <= 1'b0;
            mem_read      <= 1'b1;
            state         <= GNT_IF;
          end
        end
        GNT_IF: begin
          if (mem_done) begin
            mem_read    <= 1'b0;
            if_readdata <= {32'b0, mem_readdata[31:0]};
            if_done     <= 1'b1;
            state       <= RELEASE;
          end
        end
        GNT_DP: begin
          if (mem_done) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (!mem_write)
              dp_readdata <= mem_readdata;
            dp_done   <= 1'b1;
            state     <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmix_mem_arbiter.sv
// Randomized self-checking bench for mmix_mem_arbiter; the bench plays the memory adapter.
module tb_mmix_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] if_address = '0;
  logic        if_read = 1'b0;
  logic [63:0] if_readdata;
  logic        if_done;
  logic [63:0] dp_address = '0;
  logic [1:0]  dp_datasize = '0;
  logic        dp_read = 1'b0;
  logic        dp_write = 1'b0;
  logic [63:0] dp_writedata = '0;
  logic [63:0] dp_readdata;
  logic        dp_done;
  logic [63:0] mem_address;
  logic [1:0]  mem_datasize;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_writedata;
  logic [63:0] mem_readdata = '0;
  logic        mem_done = 1'b0;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_if_rd = '0;
  logic [63:0] exp_dp_rd = '0;
  bit          favour_if = 1'b1;

  mmix_mem_arbiter #(.ADDR_W(64), .IF_SIZE(2'd2)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_address(if_address), .if_read(if_read), .if_readdata(if_readdata), .if_done(if_done),
    .dp_address(dp_address), .dp_datasize(dp_datasize), .dp_read(dp_read), .dp_write(dp_write),
    .dp_writedata(dp_writedata), .dp_readdata(dp_readdata), .dp_done(dp_done),
    .mem_address(mem_address), .mem_datasize(mem_datasize), .mem_read(mem_read),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Which port should win given the current requests.
  function automatic bit pick_dp(input bit dp_req, input bit if_req);
`ifdef MEM_ARB_RR_EN
    if (dp_req && if_req) return !favour_if;
`endif
    return dp_req;
  endfunction

  task automatic check_cmd(input string tag, input bit is_dp);
    bit          wr;
    logic [63:0] a;
    wr = is_dp && dp_write;
    a  = is_dp ? dp_address : (if_address & ~64'd3);
    check_eq({tag, " read"},  mem_read, !wr);
    check_eq({tag, " write"}, mem_write, wr);
    check_eq({tag, " addr"},  mem_address, a);
    check_eq({tag, " size"},  mem_datasize, is_dp ? dp_datasize : 2'd2);
    if (wr) check_eq({tag, " wdata"}, mem_writedata, dp_writedata);
  endtask

  task automatic check_quiet(input string tag);
    check_eq(tag, {mem_read, mem_write, if_done, dp_done}, 4'b0000);
  endtask

  // Called just after the granting edge; holds for lat cycles then returns mem_done.
  task automatic serve(input string tag, input bit is_dp, input int unsigned lat, input logic [63:0] rdata);
    bit wr;
    wr = is_dp && dp_write;
    for (int unsigned i = 0; i < lat; i++) begin
      tick;
      check_cmd({tag, " hold"}, is_dp);
      check_eq({tag, " nodone"}, {if_done, dp_done}, 2'b00);
    end
    mem_done = 1'b1;
    mem_readdata = rdata;
    tick;
    mem_done = 1'b0;
    mem_readdata = {$urandom, $urandom};
    if (!wr) begin
      if (is_dp) exp_dp_rd = rdata;
      else       exp_if_rd = {32'b0, rdata[31:0]};
    end
    check_eq({tag, " cmd low"}, {mem_read, mem_write}, 2'b00);
    check_eq({tag, " dp_done"}, dp_done, is_dp);
    check_eq({tag, " if_done"}, if_done, !is_dp);
    check_eq({tag, " dp_rdata"}, dp_readdata, exp_dp_rd);
    check_eq({tag, " if_rdata"}, if_readdata, exp_if_rd);
  endtask

  task automatic do_txn(input string tag, input bit is_dp, input bit wr, input logic [1:0] sz,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] rdata, input int unsigned lat);
    if (is_dp) begin
      dp_address = addr; dp_datasize = sz; dp_writedata = wdata;
      dp_write = wr; dp_read = !wr;
    end else begin
      if_address = addr; if_read = 1'b1;
    end
    tick;
    favour_if = is_dp;
    check_cmd({tag, " grant"}, is_dp);
    serve(tag, is_dp, lat, rdata);
    if_read = 1'b0; dp_read = 1'b0; dp_write = 1'b0;
    tick;
    check_quiet({tag, " release"});
  endtask

  task automatic apply_reset;
    reset_n = 1'b0;
    mem_done = 1'b0;
    tick;
    tick;
    favour_if = 1'b1;
    exp_if_rd = '0;
    exp_dp_rd = '0;
    reset_n = 1'b1;
  endtask

  initial begin
    bit          d;
    logic [63:0] r;

    // Reset with a fetch pending: everything quiet, then fetch granted right after release.
    if_address = 64'h0000_0000_0040_1237;
    if_read = 1'b1;
    tick;
    tick;
    check_eq("rst cmd", {mem_read, mem_write, if_done, dp_done}, 4'b0000);
    check_eq("rst addr", mem_address, 64'd0);
    check_eq("rst size", mem_datasize, 2'd0);
    check_eq("rst wdata", mem_writedata, 64'd0);
    check_eq("rst if_rdata", if_readdata, 64'd0);
    check_eq("rst dp_rdata", dp_readdata, 64'd0);
    reset_n = 1'b1;
    tick;
    favour_if = 1'b0;
    check_cmd("first fetch", 1'b0);
    serve("first fetch", 1'b0, 2, 64'hFFFF_FFFF_8765_4321);
    if_read = 1'b0;
    tick;
    check_quiet("first fetch release");

    do_txn("octa store", 1'b1, 1'b1, 2'd3, 64'h1000, 64'hDEAD_BEEF_0123_4567, 64'h5555, 3);
    do_txn("byte load", 1'b1, 1'b0, 2'd0, 64'h2001, 64'h0, 64'h0000_0000_0000_00AB, 1);

    // Spurious mem_done while idle must not produce a done or a command.
    mem_done = 1'b1;
    mem_readdata = 64'h1234;
    tick;
    mem_done = 1'b0;
    check_quiet("spurious done");
    check_eq("spurious dp_rdata", dp_readdata, exp_dp_rd);
    tick;
    check_quiet("spurious after");
    do_txn("after spurious", 1'b0, 1'b0, 2'd0, 64'h3003, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD, 0);

    // Simultaneous requests held continuously; the release cycle separates grants.
    apply_reset;
    tick;
    dp_address = 64'h8000; dp_datasize = 2'd3; dp_read = 1'b1;
    if_address = 64'h4006; if_read = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      d = pick_dp(1'b1, 1'b1);
      tick;
      favour_if = d;
      check_cmd($sformatf("contend%0d grant", k), d);
      serve($sformatf("contend%0d", k), d, 1, {$urandom, $urandom});
      tick;
      check_quiet($sformatf("contend%0d gap", k));
    end
    dp_read = 1'b0; if_read = 1'b0;
    tick;
    check_quiet("contend idle");

    // Reset during a granted store drops the command at once and never completes it.
    dp_address = 64'h9000; dp_datasize = 2'd2; dp_writedata = 64'h77; dp_write = 1'b1;
    tick;
    check_eq("rst mid grant", mem_write, 1'b1);
    #2 reset_n = 1'b0;
    #1 check_eq("rst mid async", {mem_write, mem_read}, 2'b00);
    dp_write = 1'b0;
    mem_done = 1'b1;
    tick;
    mem_done = 1'b0;
    favour_if = 1'b1;
    exp_if_rd = '0;
    exp_dp_rd = '0;
    reset_n = 1'b1;
    tick;
    check_quiet("rst mid after");
    tick;
    check_quiet("rst mid idle");

    for (int n = 0; n < 40; n++) begin
      d = 1'($urandom_range(1, 0));
      r = {$urandom, $urandom};
      do_txn($sformatf("rnd%0d", n), d, 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)),
             {$urandom, $urandom}, {$urandom, $urandom}, r, $urandom_range(4, 0));
      if ($urandom_range(3, 0) == 0) begin
        mem_done = 1'b1;
        tick;
        mem_done = 1'b0;
        check_quiet($sformatf("rnd%0d spurious", n));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
